gimbal_sequencer: RTL and testbench
===================================

Name: gimbal_sequencer

Overview:
- Flight-phase controller for the gimbal rate path. Tracks ascent phase from height/velocity samples and enables the gimbal above the gimbal altitude.
- Computes angular-rate commands omega = v / (R_BODY + h) with an iterative divider.
- Delivers each command to the gimbal actuator over a valid/ready handshake.
- Sits between the navigation sample source and the gimbal actuator.

Parameters:
- N, 32, width of velocity, height and rate command.
- R_BODY, 6371000, body radius in metres.
- GIMBAL_ALT, 30000, gimbal-enable altitude in metres (strictly greater than).
- TARGET_ALT, 188000, orbit altitude in metres (greater or equal).
- HYST, 4, consecutive samples above GIMBAL_ALT needed to enter GIMBAL.
- RATE_SCALE, 1000000, output scale; rate_cmd is in micro-rad/s.
- WD_CYCLES, 1024, watchdog timeout in cycles (optional feature only).

Ports:
- clk  in  1  clock.
- resetb  in  1  asynchronous active-low reset.
- launch  in  1  liftoff pulse.
- abort  in  1  abort request (level or pulse).
- sample_valid  in  1  velocity/height qualifier.
- velocity  in  N  unsigned, m/s.
- height  in  N  unsigned, metres.
- cmd_ready  in  1  actuator accepts rate_cmd.
- cmd_valid  out  1  rate_cmd valid.
- rate_cmd  out  N  angular rate, micro-rad/s.
- gimbal_en  out  1  gimbal active.
- phase  out  3  0 PAD, 1 ASCENT, 2 GIMBAL, 3 ORBIT, 4 ABORT.
- busy  out  1  divider running.

Behaviour:
- Reset (resetb low, asynchronous): phase=PAD, gimbal_en=0, cmd_valid=0, rate_cmd=0, busy=0. Hysteresis counter, divider and watchdog are all cleared. Reset mid-division discards the division.
- Priority: abort, then phase logic, then divider.
- abort high in any phase except ABORT moves to ABORT on the next edge. In ABORT: gimbal_en=0, cmd_valid forced 0 (the only case valid drops without ready), divider cleared. Only resetb leaves ABORT.
- PAD: launch=1 moves to ASCENT. Samples are ignored.
- ASCENT:
  - Each sample with height > GIMBAL_ALT increments the hysteresis counter, saturating at HYST.
  - A sample with height <= GIMBAL_ALT clears the counter.
  - The edge on which the counter reaches HYST moves to GIMBAL and sets gimbal_en=1 in the same cycle.
  - TARGET_ALT is not checked in ASCENT.
- GIMBAL: a sample with height >= TARGET_ALT moves to ORBIT. That sample still launches a division. gimbal_en stays 1.
- ORBIT: gimbal_en=1, commands continue. Terminal except abort.
- phase is monotonic: there is no transition back to a lower phase. launch outside PAD is ignored.
- Division start: in GIMBAL or ORBIT, on a sample_valid with busy=0 and cmd_valid=0. Operands are latched that cycle:
  - dividend = velocity*RATE_SCALE, 2N bits.
  - divisor = R_BODY+height, N+1 bits, no overflow.
- Samples arriving while busy=1 or cmd_valid=1 are dropped, not queued.
- Divider: restoring, one quotient bit per cycle, 2N cycles. busy is high exactly those 2N cycles.
- Completion: on the cycle after the last iteration, cmd_valid=1. rate_cmd = quotient, truncated, saturated to 2^N-1 if it exceeds N bits.
- Handshake:
  - cmd_valid and rate_cmd hold stable until a cycle with cmd_valid&cmd_ready. cmd_valid clears on that edge.
  - rate_cmd keeps its last value after acceptance.
  - A new division may start on the cycle after acceptance.
- Latency from the accepted sample edge to cmd_valid: 2N+1 cycles (65 for N=32).

Optional Feature:
- Macro GIMBAL_SEQ_WATCHDOG_EN.
- Defined: a counter runs while cmd_valid=1 and cmd_ready=0, and clears on acceptance. When it reaches WD_CYCLES, phase goes to ABORT with the same ABORT behaviour as the abort input.
- Undefined: no counter, and cmd_valid may wait indefinitely.

Test Plan:
- Reset/launch: hold resetb low, then release and pulse launch → phase=1, gimbal_en=0, cmd_valid=0. Assert resetb low mid-division → all outputs zero immediately.
- Hysteresis: in ASCENT, heights 30001,30001,30000,30001×4 → phase=2 only on the 4th sample of the final run, gimbal_en=1 that cycle; the earlier 30000 clears the count.
- Rate value: in GIMBAL, velocity=7800, height=188000 → cmd_valid 65 cycles later, rate_cmd=1189, phase=3.
- Backpressure: hold cmd_ready=0 for 20 cycles and drive samples each cycle → rate_cmd stable, samples dropped. cmd_ready=1 → one transfer, next sample starts a division the following cycle.
- Abort: assert abort during busy=1 in GIMBAL → phase=4 next edge, gimbal_en=0, no cmd_valid. A later launch/sample has no effect until resetb.
- Watchdog (macro defined, WD_CYCLES=16): leave a command unaccepted → phase=4 after 16 cycles of cmd_valid=1. With the macro undefined → still waiting after 1000 cycles.

Source files
------------

// File: rtl/gimbal_sequencer.sv
// Gimbal sequencer: flight-phase tracking plus v/(R+h) rate commands over valid/ready.
// Optional command watchdog: define GIMBAL_SEQ_WATCHDOG_EN.
module gimbal_sequencer #(
    parameter int N          = 32,
    parameter int R_BODY     = 6371000,
    parameter int GIMBAL_ALT = 30000,
    parameter int TARGET_ALT = 188000,
    parameter int HYST       = 4,
    parameter int RATE_SCALE = 1000000,
    parameter int WD_CYCLES  = 1024
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         launch,
    input  logic         abort,
    input  logic         sample_valid,
    input  logic [N-1:0] velocity,
    input  logic [N-1:0] height,
    input  logic         cmd_ready,
    output logic         cmd_valid,
    output logic [N-1:0] rate_cmd,
    output logic         gimbal_en,
    output logic [2:0]   phase,
    output logic         busy
);

    typedef enum logic [2:0] {
        PH_PAD    = 3'd0,
        PH_ASCENT = 3'd1,
        PH_GIMBAL = 3'd2,
        PH_ORBIT  = 3'd3,
        PH_ABORT  = 3'd4
    } phase_t;

    localparam int HW = $clog2(HYST + 1);
    localparam int CW = $clog2(2 * N);

    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic [HW-1:0]    r_hcnt;
    logic [2*N-1:0]   r_dvd;
    logic [N:0]       r_rem;
    logic [N:0]       r_dsr;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_fin;
    logic             r_valid;
    logic [N-1:0]     r_rate;

    logic             w_above;
    logic             w_orbit_hit;
    logic             w_hyst_done;
    logic             w_wd_trip;
    logic             w_abort;
    logic             w_start;
    logic [2*N-1:0]   w_prod;
    logic [N+1:0]     w_rem_sh;
    logic             w_ge;
    logic [N:0]       w_sub;
    logic [N:0]       w_rem_nxt;
    logic [2*N-1:0]   w_quo;
    logic [N-1:0]     w_sat;

    assign w_above     = height > N'(GIMBAL_ALT);
    assign w_orbit_hit = height >= N'(TARGET_ALT);
    assign w_hyst_done = w_above && (r_hcnt == HW'(HYST - 1));
    assign w_abort     = abort || w_wd_trip;

    // Sample qualifies only when the divider and output slot are both empty
    assign w_start = !w_abort && sample_valid && !r_busy && !r_fin && !r_valid
                   && (r_phase == PH_GIMBAL || r_phase == PH_ORBIT);

    assign w_prod = {{N{1'b0}}, velocity} * (2 * N)'(RATE_SCALE);

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign w_rem_sh  = {r_rem, r_dvd[2*N-1]};
    assign w_ge      = w_rem_sh >= {1'b0, r_dsr};
    assign w_sub     = w_rem_sh[N:0] - r_dsr;
    assign w_rem_nxt = w_ge ? w_sub : w_rem_sh[N:0];
    assign w_quo     = {r_dvd[2*N-2:0], w_ge};
    assign w_sat     = (|r_dvd[2*N-1:N]) ? '1 : r_dvd[N-1:0];

    // Phase register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) r_phase <= PH_PAD;
        else         r_phase <= w_phase_nxt;
    end

    // Next phase: abort wins, otherwise phase only moves forward
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_abort) begin
            w_phase_nxt = PH_ABORT;
        end else begin
            unique case (r_phase)
                PH_PAD:    if (launch) w_phase_nxt = PH_ASCENT;
                PH_ASCENT: if (sample_valid && w_hyst_done) w_phase_nxt = PH_GIMBAL;
                PH_GIMBAL: if (sample_valid && w_orbit_hit) w_phase_nxt = PH_ORBIT;
                default:   w_phase_nxt = r_phase;
            endcase
        end
    end

    // Consecutive-above-altitude counter, saturating at HYST
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_hcnt <= '0;
        end else if (r_phase == PH_ASCENT && sample_valid) begin
            if (!w_above)                   r_hcnt <= '0;
            else if (r_hcnt != HW'(HYST))   r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Divider and output holding register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_dvd   <= '0;
            r_rem   <= '0;
            r_dsr   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            r_valid <= 1'b0;
            r_rate  <= '0;
        end else if (w_abort || r_phase == PH_ABORT) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (w_start) begin
                r_dvd  <= w_prod;
                r_dsr  <= (N + 1)'(R_BODY) + {1'b0, height};
                r_rem  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_dvd <= w_quo;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CW'(2 * N - 1)) begin
                    r_busy <= 1'b0;
                    r_fin  <= 1'b1;
                end
            end
            if (r_fin) begin
                r_fin   <= 1'b0;
                r_valid <= 1'b1;
                r_rate  <= w_sat;
            end else if (r_valid && cmd_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef GIMBAL_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WD_CYCLES + 1);
    logic [WW-1:0] r_wd;
    logic          w_wait;

    assign w_wait    = r_valid && !cmd_ready;
    assign w_wd_trip = w_wait && (r_wd == WW'(WD_CYCLES - 1));

    // Count cycles a command sits unaccepted
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)     r_wd <= '0;
        else if (w_wait) r_wd <= r_wd + 1'b1;
        else             r_wd <= '0;
    end
`else
    // No watchdog: a pending command may wait forever
    assign w_wd_trip = (WD_CYCLES < 0);
`endif

    assign cmd_valid = r_valid;
    assign rate_cmd  = r_rate;
    assign busy      = r_busy;
    assign phase     = r_phase;
    assign gimbal_en = (r_phase == PH_GIMBAL) || (r_phase == PH_ORBIT);

endmodule

// File: tb/tb_gimbal_sequencer.sv
// Directed bench for gimbal_sequencer with an expected-rate scoreboard.
// Watchdog branch follows GIMBAL_SEQ_WATCHDOG_EN.
module tb_gimbal_sequencer;

`ifdef GIMBAL_SEQ_WATCHDOG_EN
    localparam int WD = 16;
`else
    localparam int WD = 1024;
`endif

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        launch = 1'b0;
    logic        abort = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] velocity = '0;
    logic [31:0] height = '0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [31:0] rate_cmd;
    logic        gimbal_en;
    logic [2:0]  phase;
    logic        busy;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] sb[$];
    int          lat;
    bit          ok;

    gimbal_sequencer #(.WD_CYCLES(WD)) dut (
        .clk(clk), .resetb(resetb), .launch(launch), .abort(abort),
        .sample_valid(sample_valid), .velocity(velocity), .height(height),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .rate_cmd(rate_cmd),
        .gimbal_en(gimbal_en), .phase(phase), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] v, input logic [31:0] h);
        logic [63:0] d;
        logic [63:0] s;
        logic [63:0] q;
        d = 64'(v) * 64'd1000000;
        s = 64'd6371000 + 64'(h);
        q = d / s;
        return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] h, input logic [31:0] v);
        sample_valid = 1'b1;
        height = h;
        velocity = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic start(input logic [31:0] h, input logic [31:0] v);
        sb.push_back(model(v, h));
        drive(h, v);
        chk("start_busy", busy, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!cmd_valid && n < 200) begin
            tick();
            n++;
        end
        chk("valid_seen", cmd_valid, 1);
    endtask

    task automatic accept(input string tag);
        logic [31:0] e;
        chk("sb_depth", sb.size() > 0, 1);
        e = (sb.size() > 0) ? sb.pop_front() : 32'h0;
        chk(tag, rate_cmd, e);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk({tag, "_clr"}, cmd_valid, 0);
    endtask

    task automatic climb();
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        tick();
        launch = 1'b1;
        tick();
        launch = 1'b0;
        repeat (4) drive(32'd30001, 32'd0);
        chk("climb_phase", phase, 2);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] hs [7];
        logic [2:0]  ps [7];
        hs = '{32'd30001, 32'd30001, 32'd30000, 32'd30001, 32'd30001, 32'd30001, 32'd30001};
        ps = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};

        repeat (3) tick();
        chk("rst_phase", phase, 0);
        chk("rst_gimbal", gimbal_en, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_rate", rate_cmd, 0);
        chk("rst_busy", busy, 0);

        resetb = 1'b1;
        tick();
        drive(32'd200000, 32'd7800);
        chk("pad_ignore_phase", phase, 0);
        chk("pad_ignore_busy", busy, 0);
        launch = 1'b1;
        tick();
        launch = 1'b0;
        chk("launch_phase", phase, 1);
        chk("launch_gimbal", gimbal_en, 0);
        chk("launch_valid", cmd_valid, 0);

        for (int i = 0; i < 7; i++) begin
            drive(hs[i], 32'd0);
            chk("hyst_phase", phase, ps[i]);
            chk("hyst_gimbal", gimbal_en, ps[i] == 3'd2);
        end

        start(32'd188000, 32'd7800);
        chk("orbit_phase", phase, 3);
        wait_valid(lat);
        chk("latency", lat, 65);
        chk("rate_1189", rate_cmd, 1189);

        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample_valid = 1'b1;
            height = 32'd50000 + 32'(i) * 32'd1000;
            velocity = 32'(i) + 32'd1;
            tick();
            if (rate_cmd !== 32'd1189 || cmd_valid !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        sample_valid = 1'b0;
        chk("bp_stable", ok, 1);
        accept("acc_bp");
        chk("rate_hold", rate_cmd, 1189);

        start(32'd0, 32'd4000000000);
        wait_valid(lat);
        accept("acc_big_v");
        start(32'hFFFF_FFFF, 32'd123456789);
        wait_valid(lat);
        accept("acc_max_h");
        start(32'd100, 32'd6371100);
        wait_valid(lat);
        accept("acc_exact");
        start(32'd30000, 32'd1);
        wait_valid(lat);
        accept("acc_zero");

        start(32'd400000, 32'd7700);
        wait_valid(lat);
`ifdef GIMBAL_SEQ_WATCHDOG_EN
        lat = 0;
        while (phase != 3'd4 && lat < 100) begin
            tick();
            lat++;
        end
        chk("wd_trip_cycles", lat, WD);
        chk("wd_gimbal", gimbal_en, 0);
        chk("wd_valid", cmd_valid, 0);
`else
        repeat (1000) tick();
        chk("nowd_valid", cmd_valid, 1);
        chk("nowd_phase", phase, 3);
        accept("acc_nowd");
`endif

        climb();
        start(32'd100000, 32'd7000);
        repeat (10) tick();
        chk("abort_busy_pre", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
        chk("abort_phase", phase, 4);
        chk("abort_gimbal", gimbal_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", cmd_valid, 0);
        ok = 1'b1;
        repeat (80) begin
            tick();
            if (cmd_valid !== 1'b0) ok = 1'b0;
        end
        chk("abort_no_cmd", ok, 1);
        launch = 1'b1;
        drive(32'd200000, 32'd7800);
        launch = 1'b0;
        chk("abort_sticky", phase, 4);
        chk("abort_no_div", busy, 0);

        climb();
        start(32'd50000, 32'd7800);
        wait_valid(lat);
        accept("acc_pre_rst");
        start(32'd60000, 32'd7000);
        repeat (10) tick();
        #3 resetb = 1'b0;
        #1;
        chk("arst_phase", phase, 0);
        chk("arst_gimbal", gimbal_en, 0);
        chk("arst_valid", cmd_valid, 0);
        chk("arst_rate", rate_cmd, 0);
        chk("arst_busy", busy, 0);
        sb.delete();
        tick();
        resetb = 1'b1;
        ok = 1'b1;
        repeat (80) begin
            tick();
            if (cmd_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("arst_discard", ok, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
